reorder_buffer: RTL

//  In-order retirement buffer on the receiving end of the CDB. Allocates one entry per dispatched instruction and captures RS/LSB results.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_ptr_ctrl.sv | 46 ++++
 rtl/reorder_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared encodings and sizes for the reorder buffer.
// Build option: define ROB_COMMIT_TRACE_EN for commit/flush trace output.
package rob_pkg;

  localparam int ROB_W    = 4;
  localparam int ROB_SIZE = 1 << ROB_W;
  localparam int NON_DEP  = ROB_SIZE;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_JALR   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer.
// A flush returns everything to the empty state.
module rob_ptr_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic                 commit_en,
  input  logic                 clear_en,
  output logic [ROB_WIDTH-1:0] head,
  output logic [ROB_WIDTH-1:0] tail,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ROB_WIDTH:0] SIZE = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [ROB_WIDTH:0] count;

  assign full  = (count == SIZE);
  assign empty = (count == '0);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear_en) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        // Pointers wrap naturally at the power-of-two boundary.
        head  <= head + {{(ROB_WIDTH-1){1'b0}}, commit_en};
        tail  <= tail + {{(ROB_WIDTH-1){1'b0}}, alloc_en};
        count <= count + {{ROB_WIDTH{1'b0}}, alloc_en} - {{ROB_WIDTH{1'b0}}, commit_en};
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate, capture CDB results, commit head, flush on mispredict.
// Build option: ROB_COMMIT_TRACE_EN prints each commit and each flush target.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_WIDTH    = 5,
  parameter int ROB_WIDTH    = ROB_W,
  parameter int EX_ROB_WIDTH = ROB_W + 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    DP2ROB_en,
  input  logic [1:0]              DP2ROB_type,
  input  logic [REG_WIDTH-1:0]    DP2ROB_rd,
  input  logic [ADDR_WIDTH-1:0]   DP2ROB_pc,
  input  logic                    DP2ROB_pred_taken,
  output logic                    ROB2DP_full,
  output logic [ROB_WIDTH-1:0]    ROB2DP_tail,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qj,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qk,
  output logic                    ROB2DP_Vj_rdy,
  output logic                    ROB2DP_Vk_rdy,
  output logic [ADDR_WIDTH-1:0]   ROB2DP_Vj,
  output logic [ADDR_WIDTH-1:0]   ROB2DP_Vk,
  input  logic                    RS2ROB_en,
  input  logic [ROB_WIDTH-1:0]    RS2ROB_ROB_index,
  input  logic [ADDR_WIDTH-1:0]   RS2ROB_value,
  input  logic [ADDR_WIDTH-1:0]   RS2ROB_next_pc,
  input  logic                    LSB2ROB_en,
  input  logic [ROB_WIDTH-1:0]    LSB2ROB_ROB_index,
  input  logic [ADDR_WIDTH-1:0]   LSB2ROB_value,
  output logic                    ROB2RF_en,
  output logic [REG_WIDTH-1:0]    ROB2RF_rd,
  output logic [ADDR_WIDTH-1:0]   ROB2RF_value,
  output logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index,
  output logic                    ROB2LSB_commit_en,
  output logic                    ROB2ALL_clear,
  output logic [ADDR_WIDTH-1:0]   ROB2IF_new_pc
);

  localparam int SIZE = 1 << ROB_WIDTH;
  localparam logic [EX_ROB_WIDTH-1:0] NON_DEP_TAG = EX_ROB_WIDTH'(SIZE);

  logic [SIZE-1:0]       busy, ready;
  rob_type_e             e_type [SIZE];
  logic [REG_WIDTH-1:0]  e_rd   [SIZE];
  logic [ADDR_WIDTH-1:0] e_pc   [SIZE];
  logic [ADDR_WIDTH-1:0] e_val  [SIZE];
  logic [ADDR_WIDTH-1:0] e_npc  [SIZE];
  logic                  e_pred [SIZE];

  logic [ROB_WIDTH-1:0] head, tail, qj, qk;
  logic                 empty, alloc_ok, commit, mispredict, clear;

  rob_ptr_ctrl #(.ROB_WIDTH(ROB_WIDTH)) u_ptr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .alloc_en  (alloc_ok),
    .commit_en (commit),
    .clear_en  (clear),
    .head      (head),
    .tail      (tail),
    .full      (ROB2DP_full),
    .empty     (empty)
  );

  assign ROB2DP_tail = tail;
  assign alloc_ok    = rdy_in && DP2ROB_en && !ROB2DP_full;
  assign commit      = rdy_in && !empty && busy[head] && ready[head];
  assign clear       = commit && mispredict;

  always_comb begin
    mispredict = 1'b0;
    case (e_type[head])
      ROB_BRANCH: mispredict = (e_val[head][0] != e_pred[head]);
      ROB_JALR:   mispredict = 1'b1;
      default:    mispredict = 1'b0;
    endcase
  end

  // Operand query with same-cycle CDB bypass; RS has priority over LSB.
  assign qj = DP2ROB_Qj[ROB_WIDTH-1:0];
  assign qk = DP2ROB_Qk[ROB_WIDTH-1:0];

  always_comb begin
    ROB2DP_Vj_rdy = 1'b0;
    ROB2DP_Vj     = '0;
    if (DP2ROB_Qj == NON_DEP_TAG) begin
      ROB2DP_Vj_rdy = 1'b1;
    end else if (RS2ROB_en && RS2ROB_ROB_index == qj) begin
      ROB2DP_Vj_rdy = 1'b1;
      ROB2DP_Vj     = RS2ROB_value;
    end else if (LSB2ROB_en && LSB2ROB_ROB_index == qj) begin
      ROB2DP_Vj_rdy = 1'b1;
      ROB2DP_Vj     = LSB2ROB_value;
    end else if (ready[qj]) begin
      ROB2DP_Vj_rdy = 1'b1;
      ROB2DP_Vj     = e_val[qj];
    end

    ROB2DP_Vk_rdy = 1'b0;
    ROB2DP_Vk     = '0;
    if (DP2ROB_Qk == NON_DEP_TAG) begin
      ROB2DP_Vk_rdy = 1'b1;
    end else if (RS2ROB_en && RS2ROB_ROB_index == qk) begin
      ROB2DP_Vk_rdy = 1'b1;
      ROB2DP_Vk     = RS2ROB_value;
    end else if (LSB2ROB_en && LSB2ROB_ROB_index == qk) begin
      ROB2DP_Vk_rdy = 1'b1;
      ROB2DP_Vk     = LSB2ROB_value;
    end else if (ready[qk]) begin
      ROB2DP_Vk_rdy = 1'b1;
      ROB2DP_Vk     = e_val[qk];
    end
  end

  // Entry status and registered commit outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy              <= '0;
      ready             <= '0;
      ROB2RF_en         <= 1'b0;
      ROB2RF_rd         <= '0;
      ROB2RF_value      <= '0;
      ROB2RF_ROB_index  <= '0;
      ROB2LSB_commit_en <= 1'b0;
      ROB2ALL_clear     <= 1'b0;
      ROB2IF_new_pc     <= '0;
    end else begin
      ROB2RF_en         <= 1'b0;
      ROB2LSB_commit_en <= 1'b0;
      ROB2ALL_clear     <= 1'b0;
      if (rdy_in) begin
        if (commit) begin
          busy[head]       <= 1'b0;
          ready[head]      <= 1'b0;
          ROB2RF_rd        <= e_rd[head];
          ROB2RF_ROB_index <= head;
          ROB2RF_value     <= (e_type[head] == ROB_JALR) ? e_pc[head] + ADDR_WIDTH'(4) : e_val[head];
          ROB2RF_en        <= (e_type[head] == ROB_REG || e_type[head] == ROB_JALR) && (e_rd[head] != '0);
          ROB2LSB_commit_en <= (e_type[head] == ROB_STORE);
          ROB2ALL_clear    <= mispredict;
          if (mispredict) ROB2IF_new_pc <= e_npc[head];
        end
        // A flush discards everything younger, including this cycle's traffic.
        if (clear) begin
          busy  <= '0;
          ready <= '0;
        end else begin
          if (alloc_ok) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= 1'b0;
          end
          if (RS2ROB_en)  ready[RS2ROB_ROB_index]  <= 1'b1;
          if (LSB2ROB_en) ready[LSB2ROB_ROB_index] <= 1'b1;
        end
      end
    end
  end

  // Entry payload carries no reset; busy/ready qualify it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear) begin
      if (alloc_ok) begin
        e_type[tail] <= rob_type_e'(DP2ROB_type);
        e_rd[tail]   <= DP2ROB_rd;
        e_pc[tail]   <= DP2ROB_pc;
        e_pred[tail] <= DP2ROB_pred_taken;
      end
      if (RS2ROB_en) begin
        e_val[RS2ROB_ROB_index] <= RS2ROB_value;
        e_npc[RS2ROB_ROB_index] <= RS2ROB_next_pc;
      end
      if (LSB2ROB_en) e_val[LSB2ROB_ROB_index] <= LSB2ROB_value;
    end
  end

`ifdef ROB_COMMIT_TRACE_EN
  always @(posedge clk_in) begin
    if (rst_in && commit) begin
      $display("rob commit pc=%h rd=%0d value=%h type=%0d",
               e_pc[head], e_rd[head], e_val[head], e_type[head]);
      if (clear) $display("rob clear new_pc=%h", e_npc[head]);
    end
  end
`else
`endif

endmodule
